control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit single-bus RISC datapath.
- Consumes the instruction register contents and the CON flip-flop, and generates every per-cycle control strobe the datapath needs: register in/out selects, memory Read/Write, ALU OpCode, and port strobes.
- Implements fetch (T0–T2) plus per-opcode execute sequences (T3–T7) as a Moore FSM, one micro-step per clock.
- Sits between memory/IR and the datapath's control inputs.

Parameters:
- OPW, 5, opcode/ALU OpCode width
- IRW, 32, instruction width

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- IR  in  32  current instruction; opcode = IR[31:27]
- CON_FF  in  1  branch-condition result from the datapath CON register
- Stop  in  1  external run/stop request
- Run  out  1  high while sequencing instructions
- Clear  out  1  datapath clear, active-high
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select/encode controls
- PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout  out  1 each
- Read, Write  out  1 each  memory strobes
- CONin, OutportIn, InPortout  out  1 each
- OpCode  out  5  ALU operation

Behaviour:
- Output timing:
  - All outputs are a combinational decode of the state register and IR[31:27]; there is no output register.
  - Any strobe not listed for a step is 0.
  - OpCode is 0 except where stated.
- Reset:
  - While clr=0: state=RESET, Clear=1, Run=0, all other outputs 0.
  - First edge after release goes RESET→T0, so Clear stays high for exactly one cycle after deassertion.
  - Reset mid-instruction aborts immediately; no partial Write is allowed.
- Stop handling:
  - Stop is sampled only in T0.
  - Stop=1 holds T0 with all strobes 0 and Run=0.
  - Run returns to 1 on the cycle after Stop=0.
- Fetch:
  - T0: PCout, MARin, Zin, OpCode=11111 (ALU INC: B+1).
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3 decodes the new IR.
- ALU opcode codes equal instruction opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, mul 01111, div 10000, neg 10001, not 10010.
- Execute sequences (last listed step returns to T0):
  - R-type (00011–01011): T3 Grb,Rout,Yin; T4 Grc,Rout,OpCode=op,Zin; T5 Zlowout,Gra,Rin.
  - addi/andi/ori (01100/01101/01110): T3 Grb,Rout,Yin; T4 Cout,Zin with OpCode=add/and/or; T5 Zlowout,Gra,Rin.
  - ld 00000: T3 Grb,BAout,Yin; T4 Cout,OpCode=add,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
  - ldi 00001: T3–T4 as ld; T5 Zlowout,Gra,Rin.
  - st 00010: T3–T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write.
  - mul/div: T3 Gra,Rout,Yin; T4 Grb,Rout,OpCode=op,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin.
  - neg/not: T3 Grb,Rout,OpCode=op,Zin; T4 Zlowout,Gra,Rin.
  - br 10011:
    - T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,OpCode=add,Zin.
    - T6 Zlowout,PCin only if CON_FF=1. The T6 cycle is always spent, giving a fixed latency.
  - jr 10100: T3 Gra,Rout,PCin.
  - in 10110: T3 InPortout,Gra,Rin. out 10111: T3 Gra,Rout,OutportIn.
  - mfhi 11000: T3 HIout,Gra,Rin. mflo 11001: T3 LOout,Gra,Rin.
  - nop 11010, and any unlisted opcode (10101, 11100–11111): no T3 strobes, T3→T0.
  - halt 11011: T3→HALT. HALT has Run=0 and all strobes 0, and is left only by reset.
- Latency: instruction cycles = 3 fetch + listed execute steps.
  - Examples: add = 6 cycles, ld = 8 cycles, br = 7 cycles.
- Simultaneous events:
  - Stop during T1–T7 is ignored until the next T0.
  - Reset takes priority over everything.

Decomposition:
- Package control_pkg holds:
  - The state enum: RESET, T0–T7, HALT.
  - Opcode localparams.
  - ALU_INC=5'b11111.
- Sub-module step_decoder: purely combinational mapping of (state, opcode, CON_FF) to outputs and next-step-or-done. control_sequencer owns the state register and the Stop/HALT/reset logic.

Test Plan:
- Reset release: clr low 3 cycles then high → Clear=1 for exactly 1 cycle after release, Run=1, T0 strobes PCout,MARin,Zin,OpCode=11111.
- IR=0x19890000 (add R3,R1,R2) → T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,OpCode=00011; T5 Zlowout,Gra,Rin; back to T0 at cycle 7.
- IR=0x00800055 (ld R1,0x55(R0)) → T3 BAout asserted, T6 Read,MDRin, T7 MDRout,Gra,Rin; Write never asserted.
- IR=0x99000014 (brzr R2) with CON_FF=0 then 1 → T6 PCin=0 then PCin=1; both take 7 cycles.
- Stop=1 at T0 → state holds, Run=0, no strobes; Stop=0 → fetch resumes next cycle. IR=0xD8000000 → HALT; only clr recovers.
- clr asserted during st T6 → all outputs 0 immediately; Write never pulses.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types for the hardwired control unit: step states, instruction
// opcodes and the bundle of per-cycle datapath strobes.
package control_pkg;

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_INC = 5'b11111;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout, cout;
        logic pcin, pcout, irin, marin, mdrin, mdrout, yin, zin;
        logic zhighout, zlowout, hiin, hiout, loin, loout;
        logic read, write, conin, outportin, inportout;
        logic [4:0] opcode;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_step_decoder.sv
// Combinational micro-step table: (step, opcode, CON_FF) -> strobes plus
// whether this step ends the instruction or enters HALT.
module step_decoder
    import control_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] op,
    input  logic       con_ff,
    output ctrl_t      ctrl,
    output logic       last,
    output logic       halt
);

    always_comb begin
        ctrl = '0;
        last = 1'b0;
        halt = 1'b0;
        case (state)
            T0: begin ctrl.pcout = 1'b1; ctrl.marin = 1'b1; ctrl.zin = 1'b1; ctrl.opcode = ALU_INC; end
            T1: begin ctrl.zlowout = 1'b1; ctrl.pcin = 1'b1; ctrl.read = 1'b1; ctrl.mdrin = 1'b1; end
            T2: begin ctrl.mdrout = 1'b1; ctrl.irin = 1'b1; end
            T3: case (op) inside
                OP_LD, OP_LDI, OP_ST: begin ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.yin = 1'b1; end
                [OP_ADD:OP_ROL], OP_ADDI, OP_ANDI, OP_ORI:
                    begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1; end
                OP_MUL, OP_DIV: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1; end
                OP_NEG, OP_NOT: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.opcode = op; end
                OP_BR:   begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.conin = 1'b1; end
                OP_JR:   begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pcin = 1'b1; last = 1'b1; end
                OP_IN:   begin ctrl.inportout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last = 1'b1; end
                OP_OUT:  begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outportin = 1'b1; last = 1'b1; end
                OP_MFHI: begin ctrl.hiout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last = 1'b1; end
                OP_MFLO: begin ctrl.loout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last = 1'b1; end
                OP_HALT: halt = 1'b1;
                default: last = 1'b1;  // nop and unassigned opcodes
            endcase
            T4: case (op) inside
                OP_LD, OP_LDI, OP_ST: begin ctrl.cout = 1'b1; ctrl.zin = 1'b1; ctrl.opcode = OP_ADD; end
                [OP_ADD:OP_ROL]: begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.opcode = op; end
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    ctrl.cout = 1'b1; ctrl.zin = 1'b1;
                    ctrl.opcode = (op == OP_ADDI) ? OP_ADD : (op == OP_ANDI) ? OP_AND : OP_OR;
                end
                OP_MUL, OP_DIV: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.opcode = op; end
                OP_NEG, OP_NOT: begin ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last = 1'b1; end
                OP_BR:   begin ctrl.pcout = 1'b1; ctrl.yin = 1'b1; end
                default: last = 1'b1;
            endcase
            T5: case (op) inside
                OP_LD, OP_ST: begin ctrl.zlowout = 1'b1; ctrl.marin = 1'b1; end
                OP_LDI, [OP_ADD:OP_ROL], OP_ADDI, OP_ANDI, OP_ORI:
                    begin ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last = 1'b1; end
                OP_MUL, OP_DIV: begin ctrl.zlowout = 1'b1; ctrl.loin = 1'b1; end
                OP_BR:   begin ctrl.cout = 1'b1; ctrl.zin = 1'b1; ctrl.opcode = OP_ADD; end
                default: last = 1'b1;
            endcase
            T6: case (op)
                OP_LD:   begin ctrl.read = 1'b1; ctrl.mdrin = 1'b1; end
                OP_ST:   begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdrin = 1'b1; end
                OP_MUL, OP_DIV: begin ctrl.zhighout = 1'b1; ctrl.hiin = 1'b1; last = 1'b1; end
                // Branch spends this cycle either way so latency is fixed.
                OP_BR:   begin ctrl.zlowout = con_ff; ctrl.pcin = con_ff; last = 1'b1; end
                default: last = 1'b1;
            endcase
            T7: begin
                last = 1'b1;
                if (op == OP_LD) begin ctrl.mdrout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                if (op == OP_ST) ctrl.write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: owns the step register, Stop and HALT handling,
// and drives the datapath strobes decoded by step_decoder.
module control_sequencer
    import control_pkg::*;
#(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [IRW-1:0] IR,
    input  logic           CON_FF,
    input  logic           Stop,
    output logic           Run,
    output logic           Clear,
    output logic           Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic           PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin,
    output logic           Zhighout, Zlowout, HIin, HIout, LOin, LOout,
    output logic           Read, Write,
    output logic           CONin, OutportIn, InPortout,
    output logic [OPW-1:0] OpCode
);

    state_t state;
    logic   stopped;
    ctrl_t  dec_ctrl, c;
    logic   dec_last, dec_halt;
    logic   unused_ir;

    assign unused_ir = ^IR[IRW-OPW-1:0];

    step_decoder u_dec (
        .state  (state),
        .op     (IR[IRW-1 -: OPW]),
        .con_ff (CON_FF),
        .ctrl   (dec_ctrl),
        .last   (dec_last),
        .halt   (dec_halt)
    );

    // Stop parks the machine in T0; stopped masks that T0's strobes.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= RESET;
            stopped <= 1'b0;
        end else begin
            case (state)
                RESET: state <= T0;
                HALT:  state <= HALT;
                T0: begin
                    if (stopped)   stopped <= Stop;
                    else if (Stop) stopped <= 1'b1;
                    else           state   <= T1;
                end
                default: begin
                    if (dec_halt)      state <= HALT;
                    else if (dec_last) state <= T0;
                    else               state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end

    assign c     = (state == T0 && stopped) ? '0 : dec_ctrl;
    assign Clear = (state == RESET);
    assign Run   = !(state == RESET || state == HALT || (state == T0 && stopped));

    assign Gra       = c.gra;
    assign Grb       = c.grb;
    assign Grc       = c.grc;
    assign Rin       = c.rin;
    assign Rout      = c.rout;
    assign BAout     = c.baout;
    assign Cout      = c.cout;
    assign PCin      = c.pcin;
    assign PCout     = c.pcout;
    assign IRin      = c.irin;
    assign MARin     = c.marin;
    assign MDRin     = c.mdrin;
    assign MDRout    = c.mdrout;
    assign Yin       = c.yin;
    assign Zin       = c.zin;
    assign Zhighout  = c.zhighout;
    assign Zlowout   = c.zlowout;
    assign HIin      = c.hiin;
    assign HIout     = c.hiout;
    assign LOin      = c.loin;
    assign LOout     = c.loout;
    assign Read      = c.read;
    assign Write     = c.write;
    assign CONin     = c.conin;
    assign OutportIn = c.outportin;
    assign InPortout = c.inportout;
    assign OpCode    = c.opcode;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: every step of each sequence
// is compared as {Clear, Run, OpCode, strobes} against hand-derived values.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, CON_FF, Stop;
    logic [31:0] IR;
    logic        Run, Clear;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic        PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin;
    logic        Zhighout, Zlowout, HIin, HIout, LOin, LOout;
    logic        Read, Write, CONin, OutportIn, InPortout;
    logic [4:0]  OpCode;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_sequencer #(.OPW(5), .IRW(32)) dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(Run), .Clear(Clear),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Read(Read), .Write(Write), .CONin(CONin), .OutportIn(OutportIn), .InPortout(InPortout),
        .OpCode(OpCode)
    );

    localparam logic [25:0] GRA = 26'd1 << 25, GRB = 26'd1 << 24, GRC = 26'd1 << 23,
        RIN = 26'd1 << 22, ROUT = 26'd1 << 21, BAOUT = 26'd1 << 20, COUT = 26'd1 << 19,
        PCIN = 26'd1 << 18, PCOUT = 26'd1 << 17, IRIN = 26'd1 << 16, MARIN = 26'd1 << 15,
        MDRIN = 26'd1 << 14, MDROUT = 26'd1 << 13, YIN = 26'd1 << 12, ZIN = 26'd1 << 11,
        ZHI = 26'd1 << 10, ZLO = 26'd1 << 9, HIIN = 26'd1 << 8, HIOUT = 26'd1 << 7,
        LOIN = 26'd1 << 6, LOOUT = 26'd1 << 5, READ = 26'd1 << 4, WRITE = 26'd1 << 3,
        CONIN = 26'd1 << 2, OPIN = 26'd1 << 1, INPOUT = 26'd1 << 0;
    localparam logic [25:0] NONE = 26'd0;

    logic [25:0] strb;
    assign strb = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCin, PCout, IRin, MARin, MDRin,
                   MDRout, Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout,
                   Read, Write, CONin, OutportIn, InPortout};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic clear, input logic run,
                              input logic [4:0] op, input logic [25:0] s);
        chk(tag, {31'd0, Clear, Run, OpCode, strb}, {31'd0, clear, run, op, s});
    endtask

    // Advance one clock and compare against a sequencing (Run=1) step.
    task automatic step(input string tag, input logic [25:0] s, input logic [4:0] op);
        tick();
        expect_out(tag, 1'b0, 1'b1, op, s);
    endtask

    task automatic fetch_t0(input string tag);
        step(tag, PCOUT | MARIN | ZIN, 5'b11111);
    endtask

    task automatic fetch_t1_t2(input string tag);
        step({tag, "_t1"}, ZLO | PCIN | READ | MDRIN, 5'd0);
        step({tag, "_t2"}, MDROUT | IRIN, 5'd0);
    endtask

    initial begin
        clr = 1'b0; Stop = 1'b0; CON_FF = 1'b0; IR = 32'h19890000;
        tick(); tick(); tick();
        expect_out("reset_hold", 1'b1, 1'b0, 5'd0, NONE);
        clr = 1'b1;
        #1 expect_out("reset_release", 1'b1, 1'b0, 5'd0, NONE);
        fetch_t0("first_t0");

        // add R3,R1,R2
        fetch_t1_t2("add");
        step("add_t3", GRB | ROUT | YIN, 5'd0);
        step("add_t4", GRC | ROUT | ZIN, 5'b00011);
        step("add_t5", ZLO | GRA | RIN, 5'd0);
        fetch_t0("add_t0");

        // ld R1,0x55(R0)
        IR = 32'h00800055;
        fetch_t1_t2("ld");
        step("ld_t3", GRB | BAOUT | YIN, 5'd0);
        step("ld_t4", COUT | ZIN, 5'b00011);
        step("ld_t5", ZLO | MARIN, 5'd0);
        step("ld_t6", READ | MDRIN, 5'd0);
        step("ld_t7", MDROUT | GRA | RIN, 5'd0);
        fetch_t0("ld_t0");

        // brzr R2, not taken then taken
        for (int t = 0; t < 2; t++) begin
            IR = 32'h99000014;
            CON_FF = t[0];
            fetch_t1_t2("br");
            step("br_t3", GRA | ROUT | CONIN, 5'd0);
            step("br_t4", PCOUT | YIN, 5'd0);
            step("br_t5", COUT | ZIN, 5'b00011);
            step(t == 0 ? "br_t6_nt" : "br_t6_tk", t == 0 ? NONE : (ZLO | PCIN), 5'd0);
            fetch_t0("br_t0");
        end
        CON_FF = 1'b0;

        // mul R4,R5
        IR = 32'h7A280000;
        fetch_t1_t2("mul");
        step("mul_t3", GRA | ROUT | YIN, 5'd0);
        step("mul_t4", GRB | ROUT | ZIN, 5'b01111);
        step("mul_t5", ZLO | LOIN, 5'd0);
        step("mul_t6", ZHI | HIIN, 5'd0);
        fetch_t0("mul_t0");

        // andi, then unassigned opcode 10101 behaves as nop
        IR = 32'h68880007;
        fetch_t1_t2("andi");
        step("andi_t3", GRB | ROUT | YIN, 5'd0);
        step("andi_t4", COUT | ZIN, 5'b00101);
        step("andi_t5", ZLO | GRA | RIN, 5'd0);
        fetch_t0("andi_t0");
        IR = 32'hA8000000;
        fetch_t1_t2("unl");
        step("unl_t3", NONE, 5'd0);
        fetch_t0("unl_t0");

        // Stop sampled in T0
        Stop = 1'b1;
        tick(); expect_out("stop_hold1", 1'b0, 1'b0, 5'd0, NONE);
        tick(); expect_out("stop_hold2", 1'b0, 1'b0, 5'd0, NONE);
        Stop = 1'b0;
        fetch_t0("stop_resume");

        // halt: only clr recovers
        IR = 32'hD8000000;
        fetch_t1_t2("halt");
        step("halt_t3", NONE, 5'd0);
        tick(); expect_out("halt_enter", 1'b0, 1'b0, 5'd0, NONE);
        tick(); tick(); expect_out("halt_stay", 1'b0, 1'b0, 5'd0, NONE);
        clr = 1'b0;
        #1 expect_out("halt_clr", 1'b1, 1'b0, 5'd0, NONE);
        tick(); clr = 1'b1;
        fetch_t0("halt_recover");

        // st aborted by reset during T6
        IR = 32'h10800010;
        fetch_t1_t2("st");
        step("st_t3", GRB | BAOUT | YIN, 5'd0);
        step("st_t4", COUT | ZIN, 5'b00011);
        step("st_t5", ZLO | MARIN, 5'd0);
        step("st_t6", GRA | ROUT | MDRIN, 5'd0);
        #1 clr = 1'b0;
        #1 expect_out("st_abort", 1'b1, 1'b0, 5'd0, NONE);
        tick(); chk("st_no_write", {63'd0, Write}, 64'd0);
        expect_out("st_abort_hold", 1'b1, 1'b0, 5'd0, NONE);
        clr = 1'b1;
        fetch_t0("st_recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
